// File: rtl/ext_int_pkg.sv
// ext_int_pkg
//   Shared constants and types for the external interrupt front-end
//   (ext_int_ctrl and its per-line synchroniser int_line_sync).
//   Optional build macro EXT_INT_DEBOUNCE_EN (see int_line_sync) changes
//   nothing in this package.
package ext_int_pkg;

  // Number of CP0 external request inputs (IP2..IP6).
  localparam int N_LINES_DEF = 5;

  // Enable register reset value: every line enabled.
  localparam logic [4:0] EN_RESET = 5'b11111;

  // Default synchroniser depth.
  localparam int SYNC_STAGES_DEF = 2;

  // Debounce stability length and the width of its counter.
  localparam int DEB_CYCLES_DEF = 4;
  localparam int DEB_W = 4;

  // Per-line mode as encoded in the EDGE_MASK parameter.
  typedef enum logic {
    MODE_LEVEL = 1'b0,
    MODE_EDGE  = 1'b1
  } line_mode_e;

  // Decode the mode of line idx from an EDGE_MASK-style vector.
  function automatic line_mode_e line_mode(input logic [31:0] mask, input int idx);
    return mask[idx] ? MODE_EDGE : MODE_LEVEL;
  endfunction

endpackage

// File: rtl/int_line_sync.sv
// int_line_sync
//   One request line: SYNC_STAGES-deep synchroniser for an asynchronous
//   pin, optionally followed by a debounce filter.
//   Build macro: EXT_INT_DEBOUNCE_EN
//     defined   -> the synchronised value must differ from the filtered
//                  value for DEB_CYCLES consecutive cycles before the
//                  filtered value follows it; shorter pulses are dropped.
//     undefined -> the last synchroniser stage drives dout directly.
//   Ports:
//     clk  in  system clock
//     rst  in  asynchronous active-high reset
//     din  in  raw request pin (asynchronous to clk)
//     dout out synchronised (and optionally filtered) request
module int_line_sync
  import ext_int_pkg::*;
#(
  parameter int SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int DEB_CYCLES  = DEB_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout
);

  // Elaboration-time range check of the configuration.
  if (SYNC_STAGES < 2 || SYNC_STAGES > 4 || DEB_CYCLES < 2 || DEB_CYCLES > 15) begin : g_bad_cfg
    $error("int_line_sync: SYNC_STAGES must be 2..4 and DEB_CYCLES 2..15");
  end

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] sync_d;
  logic                   s;

  // Shift the pin in at bit 0; the oldest sample sits in the top bit.
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], din};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign s = sync_q[SYNC_STAGES-1];

`ifdef EXT_INT_DEBOUNCE_EN
  localparam logic [DEB_W-1:0] CNT_LAST = DEB_W'(DEB_CYCLES - 1);

  logic             filt_q;
  logic             filt_d;
  logic [DEB_W-1:0] cnt_q;
  logic [DEB_W-1:0] cnt_d;

  // Counter tracks how long s has disagreed with the filtered value.
  // Any agreement restarts it, so only an uninterrupted run of
  // DEB_CYCLES disagreeing samples moves the filtered value.
  always_comb begin
    filt_d = filt_q;
    cnt_d  = '0;
    if (s != filt_q) begin
      if (cnt_q == CNT_LAST) begin
        filt_d = s;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      filt_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      filt_q <= filt_d;
      cnt_q  <= cnt_d;
    end
  end

  assign dout = filt_q;
`else
  assign dout = s;
`endif

endmodule

// File: rtl/ext_int_ctrl.sv
// ext_int_ctrl
//   External interrupt front-end feeding CP0's 5-bit int_ input
//   (IP2..IP6). Each line is synchronised (int_line_sync), then treated
//   as a rising-edge latched request or a level request according to
//   EDGE_MASK. Edge events are held in pending until software clears
//   them; an edge arriving while pending is still set raises missed.
//   int_out is the registered AND of pending and the enable register.
//   Build macro: EXT_INT_DEBOUNCE_EN (adds a debounce filter per line,
//   lengthening pin-to-int_out latency by DEB_CYCLES).
//   Ports:
//     clk          in  system clock
//     rst          in  asynchronous active-high reset
//     irq_in       in  raw device requests, asynchronous to clk
//     en_we        in  enable register write strobe
//     en_data      in  enable register write data
//     clr_we       in  write-1-to-clear strobe
//     clr_mask     in  pending/missed bits to clear
//     en_out       out enable register
//     pending_out  out pending register
//     missed_out   out lost-edge flags
//     int_out      out registered request to CP0
//   Register interface: en_we and clr_we are single-cycle strobes with no
//   handshake; the write takes effect on the clock edge where the strobe
//   is sampled high and the new value is visible on the outputs after it.
module ext_int_ctrl
  import ext_int_pkg::*;
#(
  parameter int                 N_LINES     = N_LINES_DEF,
  parameter int                 SYNC_STAGES = SYNC_STAGES_DEF,
  parameter logic [N_LINES-1:0] EDGE_MASK   = '1,
  parameter int                 DEB_CYCLES  = DEB_CYCLES_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_LINES-1:0] irq_in,
  input  logic               en_we,
  input  logic [N_LINES-1:0] en_data,
  input  logic               clr_we,
  input  logic [N_LINES-1:0] clr_mask,
  output logic [N_LINES-1:0] en_out,
  output logic [N_LINES-1:0] pending_out,
  output logic [N_LINES-1:0] missed_out,
  output logic [N_LINES-1:0] int_out
);

  // CP0 has only five external inputs; narrower configurations leave the
  // upper CP0 bits tied to 0 at the integration level.
  if (N_LINES < 1 || N_LINES > 5) begin : g_bad_cfg
    $error("ext_int_ctrl: N_LINES must be 1..5");
  end

  logic [N_LINES-1:0] s_vec;
  logic [N_LINES-1:0] prev_q, prev_d;
  logic [N_LINES-1:0] pend_q, pend_d;
  logic [N_LINES-1:0] miss_q, miss_d;
  logic [N_LINES-1:0] en_q, en_d;
  logic [N_LINES-1:0] int_q, int_d;
  logic [N_LINES-1:0] rise;
  logic [N_LINES-1:0] clr;

  for (genvar gi = 0; gi < N_LINES; gi++) begin : g_line
    int_line_sync #(
      .SYNC_STAGES (SYNC_STAGES),
      .DEB_CYCLES  (DEB_CYCLES)
    ) u_sync (
      .clk  (clk),
      .rst  (rst),
      .din  (irq_in[gi]),
      .dout (s_vec[gi])
    );
  end

  always_comb begin
    clr    = clr_we ? clr_mask : '0;
    rise   = s_vec & ~prev_q;
    prev_d = s_vec;
    en_d   = en_we ? en_data : en_q;
    // Masking happens only here; pending keeps latching on disabled lines.
    int_d  = pend_q & en_q;
    pend_d = '0;
    miss_d = '0;
    for (int i = 0; i < N_LINES; i++) begin
      if (line_mode(32'(EDGE_MASK), i) == MODE_EDGE) begin
        // A rise in the same cycle as a clear wins: the new event is
        // kept and the stale missed flag is dropped.
        pend_d[i] = (pend_q[i] & ~clr[i]) | rise[i];
        miss_d[i] = (miss_q[i] & ~clr[i]) | (rise[i] & pend_q[i] & ~clr[i]);
      end else begin
        // Level lines mirror the device; software clears do not apply.
        pend_d[i] = s_vec[i];
        miss_d[i] = 1'b0;
      end
    end
  end

  // prev resets to 0, so a line held high through reset is seen as one
  // fresh rising edge after release rather than being lost.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_q <= '0;
      pend_q <= '0;
      miss_q <= '0;
      en_q   <= '1;
      int_q  <= '0;
    end else begin
      prev_q <= prev_d;
      pend_q <= pend_d;
      miss_q <= miss_d;
      en_q   <= en_d;
      int_q  <= int_d;
    end
  end

  assign en_out      = en_q;
  assign pending_out = pend_q;
  assign missed_out  = miss_q;
  assign int_out     = int_q;

endmodule
